joystick_sampler: RTL and testbench
===================================

Name: joystick_sampler

Overview:
Polls a two-channel joystick ADC through a req/ack handshake and averages 2^AVG_LOG2 sample pairs. It drives stable 12-bit x_val/y_val to the pacman motion block; the pacman direction thresholds are <=400, >=2300 and a neutral window of 1300-1400. A built-in prescaler sets the poll rate, and a watchdog drops stalled conversions and flags an error.

Parameters:
PERIOD, 50000, Clk cycles between poll ticks (>=8)
AVG_LOG2, 2, log2 of sample pairs averaged per output update (0..4)
TIMEOUT, 255, max Clk cycles to wait for adc_ack per request (>=1)
CENTER, 1350, reset/abort value of x_val and y_val (neutral stick)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset_n  in  1  asynchronous active-low reset
err_clr  in  1  synchronous clear of adc_err
adc_req  out  1  conversion request; held until ack
adc_ch  out  1  channel select during request: 0=X, 1=Y
adc_ack  in  1  conversion done; adc_data valid in the same cycle
adc_data  in  12  conversion result
x_val  out  12  averaged X value, held between updates
y_val  out  12  averaged Y value, held between updates
sample_valid  out  1  one-cycle pulse when x_val/y_val update
adc_err  out  1  sticky timeout flag
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values (async, Reset_n low):
  - x_val=y_val=CENTER; adc_req=0, adc_ch=0, sample_valid=0, adc_err=0, busy=0.
  - Prescaler, accumulators, pair count and watchdog all 0; state IDLE.
- Prescaler:
  - Free-running 0..PERIOD-1; tick when it reaches PERIOD-1.
  - A tick is consumed only in IDLE. A tick in any other state is dropped, not queued.
- FSM states: IDLE, REQ_X, REQ_Y, UPDATE.
  - IDLE: on tick, go to REQ_X.
  - REQ_X: adc_req=1, adc_ch=0. On the cycle adc_ack=1, add adc_data to acc_x and go to REQ_Y. adc_req is 0 for at least one cycle between requests.
  - REQ_Y: adc_req=1, adc_ch=1. On ack, add adc_data to acc_y and increment pair count.
    - If pair count reaches 2^AVG_LOG2, go to UPDATE.
    - Otherwise go to IDLE and wait for the next tick.
  - UPDATE (1 cycle):
    - x_val=acc_x>>AVG_LOG2 and y_val=acc_y>>AVG_LOG2 (truncating).
    - sample_valid=1 in this same cycle; x_val/y_val are visible with the pulse.
    - Clear accumulators and pair count; go to IDLE.
- adc_ack seen outside REQ_X/REQ_Y is ignored.
- Accumulator width is 12+AVG_LOG2 bits, unsigned, so it never overflows. The average of all-4095 samples equals 4095.
- Latency: the last Y ack is followed by the UPDATE cycle (sample_valid) on the next edge.
- Watchdog:
  - Counts cycles spent in REQ_X/REQ_Y; resets on each state entry.
  - When it reaches TIMEOUT with no ack:
    - Drop adc_req next cycle and set adc_err=1.
    - Discard the partial batch (acc and count cleared) and go to IDLE.
    - x_val/y_val keep their last updated values.
  - Ack arriving in the same cycle as expiry: ack wins, no error.
- adc_err is sticky. err_clr=1 clears it on the next edge; a simultaneous new timeout wins (adc_err stays 1).
- Reset_n asserted mid-request immediately drops adc_req and restores all reset values.
- x_val/y_val never change except in UPDATE or reset.

Test Plan:
- Reset with PERIOD=16, AVG_LOG2=2 -> x_val=y_val=1350, adc_req=0, sample_valid=0, busy=0 after Reset_n rises.
- ADC model acks in 3 cycles with X=200, Y=2500 for 4 pairs -> one sample_valid pulse; x_val=200, y_val=2500; no update before the 4th Y ack.
- X samples 1000,1001,1002,1004 -> x_val=1001 (4007>>2, truncated); all-4095 samples -> 4095 exactly.
- ADC never acks, TIMEOUT=8 -> adc_req drops after 8 cycles in REQ_X; adc_err=1; x_val/y_val unchanged; next batch restarts from pair count 0; err_clr -> adc_err=0.
- Ack on exactly cycle TIMEOUT -> sample accepted, adc_err stays 0; ack pulse while in IDLE -> no accumulation.
- Reset_n pulsed low while adc_req=1 with 2 pairs accumulated -> adc_req=0 immediately; after release, 4 new pairs are needed before sample_valid.

Source files
------------

// File: rtl/joystick_sampler.sv
// Two-channel joystick ADC poller: prescaled req/ack conversions, 2^AVG_LOG2 pair averaging,
// watchdog on stalled conversions with a sticky error flag.
module joystick_sampler #(
   parameter int PERIOD   = 50000,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 255,
   parameter int CENTER   = 1350
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        err_clr,
   output logic        adc_req,
   output logic        adc_ch,
   input  logic        adc_ack,
   input  logic [11:0] adc_data,
   output logic [11:0] x_val,
   output logic [11:0] y_val,
   output logic        sample_valid,
   output logic        adc_err,
   output logic        busy
);

   localparam int PW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int AW    = 12 + AVG_LOG2;
   localparam int CW    = AVG_LOG2 + 1;
   localparam int WW    = $clog2(TIMEOUT + 1);
   localparam int PAIRS = 1 << AVG_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ_X  = 2'd1,
      ST_REQ_Y  = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_nx_s;
   logic [PW-1:0]   pre_r;
   logic [WW-1:0]   wd_r;
   logic [CW-1:0]   pair_cnt_r;
   logic [AW-1:0]   acc_x_r;
   logic [AW-1:0]   acc_y_r;
   logic [AW-1:0]   acc_y_sum_s;
   logic            tick_s;
   logic            ack_take_s;
   logic            expire_s;
   logic            last_pair_s;
   logic            req_nx_s;
   logic            adc_req_r;
   logic            adc_ch_r;
   logic            busy_r;
   logic            sample_valid_r;
   logic            adc_err_r;
   logic [11:0]     x_val_r;
   logic [11:0]     y_val_r;

   // Truncating divide by the batch size; the accumulator is sized so this always fits 12 bits.
   function automatic logic [11:0] avg_of(input logic [AW-1:0] acc);
      return acc[AW-1:AVG_LOG2];
   endfunction

   assign tick_s      = (pre_r == PW'(PERIOD - 1));
   assign ack_take_s  = adc_req_r & adc_ack;
   assign expire_s    = adc_req_r & ~adc_ack & (wd_r == WW'(TIMEOUT - 1));
   assign last_pair_s = (pair_cnt_r == CW'(PAIRS - 1));
   assign acc_y_sum_s = acc_y_r + AW'(adc_data);

   // Free-running poll prescaler.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pre_r <= '0;
      end else if (tick_s) begin
         pre_r <= '0;
      end else begin
         pre_r <= pre_r + PW'(1);
      end
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next state; the request is held low for the first REQ_Y cycle to separate X and Y requests.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (tick_s) state_nx_s = ST_REQ_X;
            else        state_nx_s = ST_IDLE;
         end
         ST_REQ_X: begin
            if (ack_take_s)    state_nx_s = ST_REQ_Y;
            else if (expire_s) state_nx_s = ST_IDLE;
            else               state_nx_s = ST_REQ_X;
         end
         ST_REQ_Y: begin
            if (ack_take_s) begin
               if (last_pair_s) state_nx_s = ST_UPDATE;
               else             state_nx_s = ST_IDLE;
            end else if (expire_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_REQ_Y;
            end
         end
         ST_UPDATE: state_nx_s = ST_IDLE;
         default:   state_nx_s = ST_IDLE;
      endcase
      req_nx_s = (state_nx_s == ST_REQ_X) ||
                 ((state_nx_s == ST_REQ_Y) && (state_r == ST_REQ_Y));
   end

   // Watchdog: counts request-high cycles, restarted on every state change.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wd_r <= '0;
      end else if (state_nx_s != state_r) begin
         wd_r <= '0;
      end else if (adc_req_r) begin
         wd_r <= wd_r + WW'(1);
      end else begin
         wd_r <= wd_r;
      end
   end

   // Batch accumulators; a timeout throws away the partial batch.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc_x_r    <= '0;
         acc_y_r    <= '0;
         pair_cnt_r <= '0;
      end else if (expire_s || (state_r == ST_UPDATE)) begin
         acc_x_r    <= '0;
         acc_y_r    <= '0;
         pair_cnt_r <= '0;
      end else if (ack_take_s && (state_r == ST_REQ_X)) begin
         acc_x_r    <= acc_x_r + AW'(adc_data);
      end else if (ack_take_s && (state_r == ST_REQ_Y)) begin
         acc_y_r    <= acc_y_sum_s;
         pair_cnt_r <= pair_cnt_r + CW'(1);
      end else begin
         acc_x_r    <= acc_x_r;
         acc_y_r    <= acc_y_r;
         pair_cnt_r <= pair_cnt_r;
      end
   end

   // Registered handshake/status outputs, decoded from the next state.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         adc_req_r      <= 1'b0;
         adc_ch_r       <= 1'b0;
         busy_r         <= 1'b0;
         sample_valid_r <= 1'b0;
      end else begin
         adc_req_r      <= req_nx_s;
         adc_ch_r       <= (state_nx_s == ST_REQ_Y);
         busy_r         <= (state_nx_s != ST_IDLE);
         sample_valid_r <= (state_nx_s == ST_UPDATE);
      end
   end

   // Averages load on the edge entering UPDATE so they appear together with the pulse.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_val_r <= 12'(CENTER);
         y_val_r <= 12'(CENTER);
      end else if (state_nx_s == ST_UPDATE) begin
         x_val_r <= avg_of(acc_x_r);
         y_val_r <= avg_of(acc_y_sum_s);
      end else begin
         x_val_r <= x_val_r;
         y_val_r <= y_val_r;
      end
   end

   // Sticky error; a fresh timeout beats a simultaneous clear.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         adc_err_r <= 1'b0;
      end else if (expire_s) begin
         adc_err_r <= 1'b1;
      end else if (err_clr) begin
         adc_err_r <= 1'b0;
      end else begin
         adc_err_r <= adc_err_r;
      end
   end

   assign adc_req      = adc_req_r;
   assign adc_ch       = adc_ch_r;
   assign busy         = busy_r;
   assign sample_valid = sample_valid_r;
   assign adc_err      = adc_err_r;
   assign x_val        = x_val_r;
   assign y_val        = y_val_r;

endmodule

// File: tb/tb_joystick_sampler.sv
// Self-checking bench for joystick_sampler: vector table of sample batches with a scoreboard
// of expected averages, plus hand-written timeout, spurious-ack and mid-request reset sequences.
module tb_joystick_sampler;

   logic        Clk;
   logic        Reset_n;
   logic        err_clr;
   logic        adc_req;
   logic        adc_ch;
   logic        adc_ack;
   logic [11:0] adc_data;
   logic [11:0] x_val;
   logic [11:0] y_val;
   logic        sample_valid;
   logic        adc_err;
   logic        busy;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [3:0][11:0] xs;
      logic [3:0][11:0] ys;
      logic [11:0]      ex;
      logic [11:0]      ey;
   } vec_t;

   vec_t        vecs [5];
   logic [23:0] sb [$];
   logic [11:0] prev_x;
   logic [11:0] prev_y;

   joystick_sampler #(
      .PERIOD(16), .AVG_LOG2(2), .TIMEOUT(8), .CENTER(1350)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .err_clr(err_clr),
      .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
      .x_val(x_val), .y_val(y_val), .sample_valid(sample_valid),
      .adc_err(adc_err), .busy(busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every pulse must match a queued expectation; values hold otherwise.
   always @(negedge Clk) begin
      logic [23:0] e;
      if (Reset_n) begin
         if (sample_valid) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_update: got pulse x=%0d y=%0d, expected no pulse", x_val, y_val);
            end else begin
               e = sb.pop_front();
               if (x_val !== e[23:12] || y_val !== e[11:0]) begin
                  miscompares++;
                  $display("FAIL avg: got x=%0d y=%0d, expected x=%0d y=%0d",
                           x_val, y_val, e[23:12], e[11:0]);
               end
            end
         end else if (x_val !== prev_x || y_val !== prev_y) begin
            vectors++;
            miscompares++;
            $display("FAIL hold: got x=%0d y=%0d without pulse, expected x=%0d y=%0d",
                     x_val, y_val, prev_x, prev_y);
         end
      end
      prev_x = x_val;
      prev_y = y_val;
   end

   task automatic wait_req(input logic ch, output bit ok);
      int n = 0;
      while (!(adc_req === 1'b1 && adc_ch === ch) && n < 400) begin
         @(negedge Clk);
         n++;
      end
      ok = (n < 400);
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL req_wait: got no request on ch %0d in 400 cycles, expected adc_req=1", ch);
      end
   endtask

   // ADC model: ack the request on its dly-th cycle with the given data.
   task automatic serve(input logic ch, input logic [11:0] d, input int dly);
      bit ok;
      wait_req(ch, ok);
      if (ok) begin
         repeat (dly - 1) @(negedge Clk);
         adc_ack  = 1'b1;
         adc_data = d;
         @(negedge Clk);
         adc_ack  = 1'b0;
         adc_data = 12'd0;
      end
   endtask

   task automatic run_batch(input int i, input int dly);
      for (int p = 0; p < 4; p++) begin
         serve(1'b0, vecs[i].xs[p], dly);
         if (p == 3) sb.push_back({vecs[i].ex, vecs[i].ey});
         serve(1'b1, vecs[i].ys[p], dly);
      end
      chk("latency_pulse", int'(sample_valid), 1);
      @(negedge Clk);
      chk("pulse_consumed", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish by 300000, expected completion");
      $fatal(1);
   end

   initial begin
      bit ok;
      int hi;
      Reset_n  = 1'b0;
      err_clr  = 1'b0;
      adc_ack  = 1'b0;
      adc_data = 12'd0;

      vecs[0] = '{xs: {12'd200, 12'd200, 12'd200, 12'd200},
                  ys: {12'd2500, 12'd2500, 12'd2500, 12'd2500}, ex: 12'd200, ey: 12'd2500};
      vecs[1] = '{xs: {12'd1004, 12'd1002, 12'd1001, 12'd1000},
                  ys: {12'd1303, 12'd1302, 12'd1301, 12'd1300}, ex: 12'd1001, ey: 12'd1301};
      vecs[2] = '{xs: {12'd4095, 12'd4095, 12'd4095, 12'd4095},
                  ys: {12'd4095, 12'd4095, 12'd4095, 12'd4095}, ex: 12'd4095, ey: 12'd4095};
      vecs[3] = '{xs: {12'd3, 12'd2, 12'd1, 12'd0},
                  ys: {12'd403, 12'd400, 12'd400, 12'd400}, ex: 12'd1, ey: 12'd400};
      vecs[4] = '{xs: {12'd4095, 12'd0, 12'd2301, 12'd2300},
                  ys: {12'd8, 12'd4, 12'd2, 12'd1}, ex: 12'd2174, ey: 12'd3};

      repeat (3) @(negedge Clk);
      #2 Reset_n = 1'b1;
      @(negedge Clk);
      chk("rst_x_val", x_val, 1350);
      chk("rst_y_val", y_val, 1350);
      chk("rst_adc_req", int'(adc_req), 0);
      chk("rst_sample_valid", int'(sample_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_adc_err", int'(adc_err), 0);

      for (int i = 0; i < 5; i++) begin
         run_batch(i, 3);
         chk("batch_x", x_val, int'(vecs[i].ex));
         chk("batch_y", y_val, int'(vecs[i].ey));
      end

      // Two good pairs, then an X request that is never acknowledged.
      serve(1'b0, 12'd111, 3); serve(1'b1, 12'd222, 3);
      serve(1'b0, 12'd333, 3); serve(1'b1, 12'd444, 3);
      wait_req(1'b0, ok);
      hi = 0;
      while (adc_req === 1'b1 && hi < 50) begin
         hi++;
         @(negedge Clk);
      end
      chk("timeout_req_cycles", hi, 8);
      chk("timeout_err", int'(adc_err), 1);
      chk("timeout_busy", int'(busy), 0);
      chk("timeout_x_hold", x_val, 2174);
      chk("timeout_y_hold", y_val, 3);
      repeat (3) @(negedge Clk);
      chk("err_sticky", int'(adc_err), 1);
      err_clr = 1'b1;
      @(negedge Clk);
      err_clr = 1'b0;
      chk("err_clr", int'(adc_err), 0);

      // Fresh batch after the timeout must need all four pairs again.
      run_batch(0, 3);

      // Acks landing on the last permitted watchdog cycle are accepted.
      run_batch(1, 8);
      chk("ack_at_timeout_no_err", int'(adc_err), 0);

      // Ack pulse while idle must not accumulate.
      chk("idle_before_spurious", int'(busy), 0);
      adc_ack  = 1'b1;
      adc_data = 12'd4095;
      @(negedge Clk);
      adc_ack  = 1'b0;
      adc_data = 12'd0;
      run_batch(3, 3);

      // Reset in the middle of a request with two pairs accumulated.
      serve(1'b0, 12'd4000, 3); serve(1'b1, 12'd4000, 3);
      serve(1'b0, 12'd4000, 3); serve(1'b1, 12'd4000, 3);
      wait_req(1'b0, ok);
      #2 Reset_n = 1'b0;
      #1;
      chk("midrst_adc_req", int'(adc_req), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_x_val", x_val, 1350);
      chk("midrst_y_val", y_val, 1350);
      @(negedge Clk);
      #2 Reset_n = 1'b1;
      run_batch(4, 3);
      chk("post_rst_x", x_val, 2174);

      repeat (4) @(negedge Clk);
      chk("sb_empty_end", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
